// File: rtl/charbuf_write_sched.sv
// Write-port scheduler for the 80x32 character buffer RAM: launches the init
// engine for screen-maintenance commands and arbitrates terminal writes.
module charbuf_write_sched #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 7,
  parameter int STARVE_MAX    = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [1:0]        cmdOp,
  input  logic [4:0]        cmdRow,
  input  logic [6:0]        cmdCol,
  output logic              initEnableN,
  output logic              initRowOnly,
  output logic              initSequential,
  output logic              initUpdateStatus,
  output logic [4:0]        initRow,
  output logic [6:0]        initCol,
  input  logic              initWrEn,
  input  logic [ADDR_W-1:0] initAddress,
  input  logic [DATA_W-1:0] initData,
  input  logic              termWrReq,
  output logic              termWrAck,
  input  logic [ADDR_W-1:0] termAddress,
  input  logic [DATA_W-1:0] termData,
  output logic              ramWrEn,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramData,
  output logic              busy,
  output logic              doneStrobe,
  output logic [11:0]       lastOpCount,
  output logic              startErr
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_RUN        = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_op;
  logic [4:0]      r_row;
  logic [6:0]      r_col;
  logic [SW-1:0]   r_starve;
  logic [TW-1:0]   r_wait;
  logic [11:0]     r_cnt;
  logic [11:0]     r_last;
  logic            r_start_err;
  logic            w_idle;
  logic            w_cmd_turn;
  logic            w_term_ack;
  logic            w_timeout;

  // Arbitration: a pending command wins once the terminal is idle or has had its quota.
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_cmd_turn = w_idle & cmdValid & (~termWrReq | (r_starve == SW'(STARVE_MAX)));
    w_term_ack = w_idle & termWrReq & ~initWrEn & ~w_cmd_turn;
  end

  // Next-state logic.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_turn) w_next = S_LAUNCH;
        else            w_next = S_IDLE;
      end
      S_LAUNCH: w_next = S_WAIT_START;
      S_WAIT_START: begin
        if (initWrEn) begin
          w_next = S_RUN;
        end else if (r_wait == TW'(START_TIMEOUT - 1)) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_next = S_WAIT_START;
        end
      end
      S_RUN: begin
        if (!initWrEn) w_next = S_DONE;
        else           w_next = S_RUN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Init engine always owns the RAM port when it is writing.
  always_comb begin
    if (initWrEn) begin
      ramWrEn    = 1'b1;
      ramAddress = initAddress;
      ramData    = initData;
    end else if (w_term_ack) begin
      ramWrEn    = 1'b1;
      ramAddress = termAddress;
      ramData    = termData;
    end else begin
      ramWrEn    = 1'b0;
      ramAddress = {ADDR_W{1'b0}};
      ramData    = {DATA_W{1'b0}};
    end
  end

  // Outputs decoded from registered state and latched command.
  always_comb begin
    cmdReady         = w_cmd_turn;
    termWrAck        = w_term_ack;
    initEnableN      = ~((r_state == S_LAUNCH) & (r_op != 2'd3));
    initUpdateStatus = (r_state == S_LAUNCH) & (r_op == 2'd3);
    initRowOnly      = ~w_idle & (r_op == 2'd2);
    initSequential   = ~w_idle & (r_op == 2'd1);
    initRow          = r_row;
    initCol          = r_col;
    busy             = ~w_idle;
    doneStrobe       = (r_state == S_DONE);
    lastOpCount      = r_last;
    startErr         = r_start_err;
  end

  // State register and command latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_row   <= 5'd0;
      r_col   <= 7'd0;
    end else begin
      r_state <= w_next;
      if (w_cmd_turn) begin
        r_op  <= cmdOp;
        r_row <= cmdRow;
        r_col <= cmdCol;
      end
    end
  end

  // Starvation counter: terminal grants seen while a command waits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve <= {SW{1'b0}};
    end else if (!cmdValid || w_cmd_turn) begin
      r_starve <= {SW{1'b0}};
    end else if (w_term_ack && (r_starve != SW'(STARVE_MAX))) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Start watchdog, write counter, result capture and sticky start error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait      <= {TW{1'b0}};
      r_cnt       <= 12'd0;
      r_last      <= 12'd0;
      r_start_err <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_wait <= {TW{1'b0}};
        r_cnt  <= 12'd0;
      end else begin
        // The first write is seen in WAIT_START, so it counts too.
        if (((r_state == S_WAIT_START) || (r_state == S_RUN)) && initWrEn)
          r_cnt <= r_cnt + 12'd1;
        if ((r_state == S_WAIT_START) && !initWrEn)
          r_wait <= r_wait + TW'(1);
      end
      if ((r_state == S_RUN) && !initWrEn) r_last <= r_cnt;
      if (w_timeout) r_start_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_charbuf_write_sched.sv
// Bench for charbuf_write_sched: behavioural init engine, per-cycle RAM port
// monitor and command-level expectations derived from screen geometry.
module tb_charbuf_write_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmdValid, cmdReady;
  logic [1:0]  cmdOp;
  logic [4:0]  cmdRow;
  logic [6:0]  cmdCol;
  logic        initEnableN, initRowOnly, initSequential, initUpdateStatus;
  logic [4:0]  initRow;
  logic [6:0]  initCol;
  logic        initWrEn;
  logic [11:0] initAddress;
  logic [6:0]  initData;
  logic        termWrReq, termWrAck;
  logic [11:0] termAddress;
  logic [6:0]  termData;
  logic        ramWrEn;
  logic [11:0] ramAddress;
  logic [6:0]  ramData;
  logic        busy, doneStrobe, startErr;
  logic [11:0] lastOpCount;

  int   total = 0;
  int   bad = 0;
  bit   rand_term = 1'b0;
  bit   eng_dead = 1'b0;
  bit   s_ready, s_ack, s_done, s_upd, s_enl, s_busy;
  int   c_acks_pre, c_acks_busy, c_ready, c_done, c_upd, c_enl, c_busy;
  bit   c_timeout;
  logic [11:0] wr_a[$];
  logic [6:0]  wr_d[$];
  logic [11:0] exp_a[$];
  logic [6:0]  exp_d[$];

  charbuf_write_sched dut (
    .clk(clk), .resetn(resetn),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdRow(cmdRow), .cmdCol(cmdCol),
    .initEnableN(initEnableN), .initRowOnly(initRowOnly), .initSequential(initSequential),
    .initUpdateStatus(initUpdateStatus), .initRow(initRow), .initCol(initCol),
    .initWrEn(initWrEn), .initAddress(initAddress), .initData(initData),
    .termWrReq(termWrReq), .termWrAck(termWrAck), .termAddress(termAddress), .termData(termData),
    .ramWrEn(ramWrEn), .ramAddress(ramAddress), .ramData(ramData),
    .busy(busy), .doneStrobe(doneStrobe), .lastOpCount(lastOpCount), .startErr(startErr)
  );

  always #5 clk = ~clk;

  // Stand-in charBufferInit: reacts to the mode pins at launch, then streams writes.
  initial begin : engine
    logic [11:0] q_a[$];
    logic [6:0]  q_d[$];
    int          dly;
    logic [4:0]  sr;
    dly = 0;
    initWrEn = 1'b0; initAddress = 12'd0; initData = 7'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        q_a.delete(); q_d.delete(); dly = 0;
      end else if (!eng_dead && (!initEnableN || initUpdateStatus)) begin
        if (initUpdateStatus) begin
          sr = initRow - 5'd1;
          for (int c = 0; c < 80; c++) begin q_a.push_back({7'(c), sr}); q_d.push_back(7'd127); end
        end else if (initRowOnly) begin
          for (int c = int'(initCol); c < 80; c++) begin q_a.push_back({7'(c), initRow}); q_d.push_back(7'd0); end
        end else begin
          for (int i = 0; i < 2560; i++) begin
            q_a.push_back(12'(i));
            q_d.push_back(initSequential ? 7'(i) : 7'd0);
          end
        end
        dly = int'($urandom_range(2, 0));
      end
      @(posedge clk); #1;
      if (!resetn || q_a.size() == 0) begin
        initWrEn = 1'b0;
      end else if (dly > 0) begin
        dly--; initWrEn = 1'b0;
      end else begin
        initWrEn = 1'b1; initAddress = q_a.pop_front(); initData = q_d.pop_front();
      end
    end
  end

  // One clock: sample and check the RAM port mid-cycle, then step past the edge.
  task automatic tick();
    @(negedge clk);
    s_ready = cmdReady; s_ack = termWrAck; s_done = doneStrobe;
    s_upd = initUpdateStatus; s_enl = ~initEnableN; s_busy = busy;
    if (resetn) begin
      total++;
      if (initWrEn) begin
        if (ramWrEn !== 1'b1 || ramAddress !== initAddress || ramData !== initData || termWrAck !== 1'b0) begin
          bad++;
          $display("FAIL ram_init_path: wr=%b addr=%h data=%h ack=%b required wr=1 addr=%h data=%h ack=0",
                   ramWrEn, ramAddress, ramData, termWrAck, initAddress, initData);
        end
        wr_a.push_back(ramAddress); wr_d.push_back(ramData);
      end else if (termWrAck) begin
        if (ramWrEn !== 1'b1 || ramAddress !== termAddress || ramData !== termData || busy !== 1'b0 || termWrReq !== 1'b1) begin
          bad++;
          $display("FAIL ram_term_path: wr=%b addr=%h data=%h busy=%b req=%b required wr=1 addr=%h data=%h busy=0 req=1",
                   ramWrEn, ramAddress, ramData, busy, termWrReq, termAddress, termData);
        end
      end else if (ramWrEn !== 1'b0) begin
        bad++;
        $display("FAIL ram_idle: ramWrEn=%b required 0", ramWrEn);
      end
      if (!busy && !cmdValid && !initWrEn) begin
        total++;
        if (termWrAck !== termWrReq) begin
          bad++;
          $display("FAIL term_grant_idle: termWrAck=%b required %b", termWrAck, termWrReq);
        end
      end
    end
    @(posedge clk); #1;
    if (rand_term) begin
      termWrReq   = 1'($urandom_range(1, 0));
      termAddress = 12'($urandom_range(2559, 0));
      termData    = 7'($urandom_range(127, 0));
    end
  endtask

  // Expected init-engine writes for a command, from screen geometry.
  task automatic build_exp(input logic [1:0] op, input logic [4:0] row, input logic [6:0] col);
    logic [4:0] srow;
    exp_a.delete(); exp_d.delete();
    srow = row - 5'd1;
    case (op)
      2'd0, 2'd1: for (int i = 0; i < 2560; i++) begin
        exp_a.push_back(12'(i)); exp_d.push_back((op == 2'd1) ? 7'(i) : 7'd0);
      end
      2'd2: for (int c = int'(col); c < 80; c++) begin exp_a.push_back({7'(c), row}); exp_d.push_back(7'd0); end
      default: for (int c = 0; c < 80; c++) begin exp_a.push_back({7'(c), srow}); exp_d.push_back(7'd127); end
    endcase
  endtask

  function automatic int list_mismatch(input int ws);
    int mm;
    mm = 0;
    if (wr_a.size() - ws != exp_a.size()) return -1;
    for (int i = 0; i < exp_a.size(); i++)
      if (wr_a[ws + i] !== exp_a[i] || wr_d[ws + i] !== exp_d[i]) mm++;
    return mm;
  endfunction

  // Present a command, hold it until accepted, then run until busy drops.
  task automatic issue_cmd(input logic [1:0] op, input logic [4:0] row, input logic [6:0] col);
    int n;
    c_acks_pre = 0; c_acks_busy = 0; c_ready = 0; c_done = 0; c_upd = 0; c_enl = 0; c_busy = 0;
    c_timeout = 1'b0;
    cmdOp = op; cmdRow = row; cmdCol = col; cmdValid = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      if (s_ack) c_acks_pre++;
      if (s_ready) c_ready++;
    end while (!s_ready && n < 200);
    cmdValid = 1'b0;
    cmdOp = 2'($urandom_range(3, 0)); cmdRow = 5'($urandom_range(31, 0)); cmdCol = 7'($urandom_range(127, 0));
    if (!s_ready) begin
      c_timeout = 1'b1;
    end else begin
      n = 0;
      do begin
        tick(); n++;
        if (s_ready) c_ready++;
        if (s_busy && s_ack) c_acks_busy++;
        if (s_done) c_done++;
        if (s_upd) c_upd++;
        if (s_enl) c_enl++;
        if (s_busy) c_busy++;
      end while (s_busy && n < 4000);
      if (s_busy) c_timeout = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    total++;
    if ({busy, initEnableN, cmdReady, doneStrobe, startErr, initRowOnly, initSequential, initUpdateStatus,
         initRow, initCol, lastOpCount} !== 32'h4000_0000 || termWrAck !== 1'b0 || ramWrEn !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: busy=%b enN=%b rdy=%b done=%b err=%b ro=%b seq=%b upd=%b row=%0d col=%0d last=%0d ack=%b wr=%b required enN=1 others 0",
               busy, initEnableN, cmdReady, doneStrobe, startErr, initRowOnly, initSequential, initUpdateStatus,
               initRow, initCol, lastOpCount, termWrAck, ramWrEn);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_cls();
    int ws;
    ws = wr_a.size();
    build_exp(2'd0, 5'd0, 7'd0);
    issue_cmd(2'd0, 5'($urandom_range(31, 0)), 7'($urandom_range(79, 0)));
    total++;
    if (c_timeout !== 1'b0 || {8'(c_ready), 8'(c_done), 8'(c_enl), 8'(c_upd), 8'(c_acks_busy)} !== 40'h01_01_01_00_00) begin
      bad++;
      $display("FAIL cls_handshake: timeout=%b ready=%0d done=%0d enl=%0d upd=%0d acks=%0d required 0 1 1 1 0 0",
               c_timeout, c_ready, c_done, c_enl, c_upd, c_acks_busy);
    end
    total++;
    if (lastOpCount !== 12'd2560) begin bad++; $display("FAIL cls_count: lastOpCount=%0d required 2560", lastOpCount); end
    total++;
    if (list_mismatch(ws) !== 0) begin
      bad++; $display("FAIL cls_writes: mismatch=%0d writes=%0d required 0 of 2560", list_mismatch(ws), wr_a.size() - ws);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL cls_busy_end: busy=%b required 0", busy); end
  endtask

  task automatic test_erase_eol();
    int ws;
    ws = wr_a.size();
    build_exp(2'd2, 5'd5, 7'd70);
    issue_cmd(2'd2, 5'd5, 7'd70);
    total++;
    if (lastOpCount !== 12'd10 || c_done !== 1) begin
      bad++; $display("FAIL eol_count: lastOpCount=%0d done=%0d required 10 1", lastOpCount, c_done);
    end
    total++;
    if (list_mismatch(ws) !== 0) begin
      bad++; $display("FAIL eol_writes: mismatch=%0d writes=%0d required 0 of 10", list_mismatch(ws), wr_a.size() - ws);
    end
  endtask

  task automatic test_status();
    int ws;
    ws = wr_a.size();
    build_exp(2'd3, 5'd0, 7'd0);
    issue_cmd(2'd3, 5'd0, 7'd33);
    total++;
    if (c_timeout !== 1'b0 || {8'(c_ready), 8'(c_done), 8'(c_enl), 8'(c_upd), 8'(c_acks_busy)} !== 40'h01_01_00_01_00) begin
      bad++;
      $display("FAIL status_handshake: timeout=%b ready=%0d done=%0d enl=%0d upd=%0d acks=%0d required 0 1 1 0 1 0",
               c_timeout, c_ready, c_done, c_enl, c_upd, c_acks_busy);
    end
    total++;
    if (lastOpCount !== 12'd80) begin bad++; $display("FAIL status_count: lastOpCount=%0d required 80", lastOpCount); end
    total++;
    if (list_mismatch(ws) !== 0) begin
      bad++; $display("FAIL status_writes: mismatch=%0d writes=%0d required 0 of 80 on row 31", list_mismatch(ws), wr_a.size() - ws);
    end
  endtask

  task automatic test_starvation();
    int ws;
    rand_term = 1'b0;
    termWrReq = 1'b1; termAddress = 12'h123; termData = 7'h55;
    repeat (3) tick();
    ws = wr_a.size();
    build_exp(2'd2, 5'd9, 7'd75);
    issue_cmd(2'd2, 5'd9, 7'd75);
    total++;
    if (c_acks_pre !== 8 || c_acks_busy !== 0) begin
      bad++; $display("FAIL starve_grants: before_ready=%0d while_busy=%0d required 8 0", c_acks_pre, c_acks_busy);
    end
    total++;
    if (lastOpCount !== 12'd5 || list_mismatch(ws) !== 0) begin
      bad++; $display("FAIL starve_cmd: lastOpCount=%0d mismatch=%0d required 5 0", lastOpCount, list_mismatch(ws));
    end
    repeat (3) tick();
    termWrReq = 1'b0;
  endtask

  task automatic test_start_timeout();
    int ws;
    eng_dead = 1'b1;
    ws = wr_a.size();
    issue_cmd(2'd0, 5'd0, 7'd0);
    total++;
    if (c_timeout !== 1'b0 || c_done !== 0 || c_busy !== 5 || startErr !== 1'b1 || wr_a.size() != ws) begin
      bad++;
      $display("FAIL start_timeout: timeout=%b done=%0d busy_cycles=%0d startErr=%b writes=%0d required 0 0 5 1 0",
               c_timeout, c_done, c_busy, startErr, wr_a.size() - ws);
    end
    eng_dead = 1'b0;
    ws = wr_a.size();
    build_exp(2'd2, 5'd17, 7'd78);
    issue_cmd(2'd2, 5'd17, 7'd78);
    total++;
    if (startErr !== 1'b1 || lastOpCount !== 12'd2 || c_done !== 1 || list_mismatch(ws) !== 0) begin
      bad++;
      $display("FAIL start_err_sticky: startErr=%b lastOpCount=%0d done=%0d mismatch=%0d required 1 2 1 0",
               startErr, lastOpCount, c_done, list_mismatch(ws));
    end
  endtask

  task automatic test_mid_reset();
    int ws, n;
    ws = wr_a.size();
    cmdOp = 2'd0; cmdRow = 5'd0; cmdCol = 7'd0; cmdValid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!s_ready && n < 200);
    cmdValid = 1'b0;
    n = 0;
    while ((wr_a.size() - ws) < 1000 && n < 3000) begin tick(); n++; end
    total++;
    if ((wr_a.size() - ws) < 1000 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_reset_progress: writes=%0d busy=%b required 1000 1", wr_a.size() - ws, busy);
    end
    #1 resetn = 1'b0;
    #1;
    total++;
    if ({busy, initEnableN, cmdReady, doneStrobe, startErr, initRowOnly, initSequential, initUpdateStatus,
         initRow, initCol, lastOpCount} !== 32'h4000_0000) begin
      bad++;
      $display("FAIL mid_reset_values: busy=%b enN=%b rdy=%b done=%b err=%b ro=%b seq=%b upd=%b last=%0d required enN=1 others 0",
               busy, initEnableN, cmdReady, doneStrobe, startErr, initRowOnly, initSequential, initUpdateStatus, lastOpCount);
    end
    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();
    ws = wr_a.size();
    build_exp(2'd0, 5'd0, 7'd0);
    issue_cmd(2'd0, 5'd3, 7'd4);
    total++;
    if (lastOpCount !== 12'd2560 || c_done !== 1 || list_mismatch(ws) !== 0) begin
      bad++; $display("FAIL post_reset_cls: lastOpCount=%0d done=%0d mismatch=%0d required 2560 1 0",
                      lastOpCount, c_done, list_mismatch(ws));
    end
  endtask

  task automatic test_random();
    int ws, exp_cnt;
    logic [1:0] op;
    logic [4:0] row;
    logic [6:0] col;
    rand_term = 1'b1;
    for (int k = 0; k < 6; k++) begin
      op  = 2'($urandom_range(3, 0));
      row = 5'($urandom_range(31, 0));
      col = 7'($urandom_range(79, 0));
      exp_cnt = (op == 2'd3) ? 80 : (op == 2'd2) ? (80 - int'(col)) : 2560;
      repeat (int'($urandom_range(6, 1))) tick();
      ws = wr_a.size();
      build_exp(op, row, col);
      issue_cmd(op, row, col);
      total++;
      if (c_timeout !== 1'b0 || {8'(c_ready), 8'(c_done), 8'(c_enl), 8'(c_upd), 8'(c_acks_busy)} !==
          {8'd1, 8'd1, 8'(op != 2'd3), 8'(op == 2'd3), 8'd0}) begin
        bad++;
        $display("FAIL rand_handshake op=%0d: timeout=%b ready=%0d done=%0d enl=%0d upd=%0d acks=%0d required 0 1 1 %0d %0d 0",
                 op, c_timeout, c_ready, c_done, c_enl, c_upd, c_acks_busy, op != 2'd3, op == 2'd3);
      end
      total++;
      if (lastOpCount !== 12'(exp_cnt) || list_mismatch(ws) !== 0) begin
        bad++; $display("FAIL rand_writes op=%0d row=%0d col=%0d: lastOpCount=%0d mismatch=%0d required %0d 0",
                        op, row, col, lastOpCount, list_mismatch(ws), exp_cnt);
      end
    end
    rand_term = 1'b0;
    termWrReq = 1'b0;
  endtask

  initial begin
    cmdValid = 1'b0; cmdOp = 2'd0; cmdRow = 5'd0; cmdCol = 7'd0;
    termWrReq = 1'b0; termAddress = 12'd0; termData = 7'd0;
    test_reset();
    test_cls();
    test_erase_eol();
    test_status();
    build_exp(2'd1, 5'd0, 7'd0);
    begin : fill_seq
      int ws;
      ws = wr_a.size();
      issue_cmd(2'd1, 5'd7, 7'd7);
      total++;
      if (lastOpCount !== 12'd2560 || c_done !== 1 || list_mismatch(ws) !== 0) begin
        bad++; $display("FAIL fill_seq: lastOpCount=%0d done=%0d mismatch=%0d required 2560 1 0",
                        lastOpCount, c_done, list_mismatch(ws));
      end
    end
    test_starvation();
    test_start_timeout();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/charbuf_write_sched.md
Name: charbuf_write_sched

Overview:
Schedules the single write port of the 2560-entry character buffer RAM (80 cols x 32 rows, address {col[6:0],row[4:0]}). It accepts screen-maintenance commands (clear, sequential fill, erase-to-end-of-line, status-row update) and sequences the charBufferInit engine through its enable/mode pins, then waits for it to finish. It also arbitrates terminal character writes against the init engine, with an anti-starvation rule for pending commands. It sits between the terminal command parser, charBufferInit and the character RAM.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 7, character code width
STARVE_MAX, 8, consecutive terminal grants allowed while a command is pending
START_TIMEOUT, 4, cycles allowed for the init engine to start writing after launch

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
cmdValid  in  1  command request
cmdReady  out  1  one-cycle command accept
cmdOp  in  2  0=CLS, 1=FILL_SEQ, 2=ERASE_EOL, 3=STATUS
cmdRow  in  5  row for ERASE_EOL; scroll row for STATUS
cmdCol  in  7  start column for ERASE_EOL
initEnableN  out  1  to init enable; active-low launch pulse
initRowOnly  out  1  to init initRowOnly
initSequential  out  1  to init sequential
initUpdateStatus  out  1  to init updateStatusRow; one-cycle pulse
initRow  out  5  to init rowInitRow
initCol  out  7  to init rowInitCol
initWrEn  in  1  from init engine
initAddress  in  ADDR_W  from init engine
initData  in  DATA_W  from init engine
termWrReq  in  1  terminal write request
termWrAck  out  1  terminal write granted this cycle (combinational)
termAddress  in  ADDR_W  terminal write address
termData  in  DATA_W  terminal write data
ramWrEn  out  1  RAM write enable
ramAddress  out  ADDR_W  RAM write address
ramData  out  DATA_W  RAM write data
busy  out  1  state != IDLE
doneStrobe  out  1  one-cycle pulse on command completion
lastOpCount  out  12  RAM writes made by the init engine during the last command
startErr  out  1  sticky: init engine failed to start

Behaviour:
- Reset (async, resetn=0): state IDLE. initEnableN=1. cmdReady, initUpdateStatus, initRowOnly, initSequential, doneStrobe and startErr are 0. initRow, initCol, lastOpCount and starveCnt are 0.
- States: IDLE, LAUNCH, WAIT_START, RUN, DONE.
- IDLE:
  - termWrAck = termWrReq & ~initWrEn & ~cmdTurn.
  - cmdTurn = cmdValid & (~termWrReq | starveCnt==STARVE_MAX).
  - If cmdTurn: cmdReady=1 for one cycle. Latch op, row and col. Clear starveCnt. Go to LAUNCH.
  - starveCnt increments on each termWrAck while cmdValid=1, saturating at STARVE_MAX. It clears when cmdValid=0.
- Mode outputs:
  - Held stable from LAUNCH until IDLE is re-entered.
  - initRowOnly = (op==ERASE_EOL).
  - initSequential = (op==FILL_SEQ).
  - initRow = latched row; initCol = latched col.
- LAUNCH: lasts exactly one cycle.
  - op 0, 1 or 2: initEnableN=0.
  - op 3: initUpdateStatus=1.
  - Clear the write counter. Go to WAIT_START.
- WAIT_START:
  - When initWrEn=1, go to RUN.
  - If initWrEn is not seen within START_TIMEOUT cycles: set startErr and return to IDLE with no doneStrobe.
- RUN:
  - Count each cycle with initWrEn=1 (12-bit counter).
  - When initWrEn=0, go to DONE.
- DONE: lasts one cycle. doneStrobe=1. lastOpCount = counter. Go to IDLE.
- RAM mux (combinational):
  - If initWrEn=1, the RAM takes initAddress and initData with ramWrEn=1.
  - Else if termWrAck=1, the RAM takes termAddress and termData with ramWrEn=1.
  - Else ramWrEn=0. Address and data outputs are don't-care.
- The init engine always wins the RAM port. termWrAck=0 in every non-IDLE state.
- cmdReady=0 outside IDLE. A command presented while busy waits; cmdValid must be held until cmdReady.
- Expected write counts:
  - CLS and FILL_SEQ: 2560.
  - ERASE_EOL from column c: 80-c.
  - STATUS: 80, at row cmdRow-1 mod 32.
- startErr clears only on reset.
- Reset asserted mid-command: immediate return to IDLE with reset values. The init engine shares resetn.

Test Plan:
- CLS, no terminal traffic -> cmdReady 1 cycle; 2560 RAM writes with data 0; termWrAck=0 throughout; one doneStrobe; lastOpCount=2560; busy falls after DONE.
- ERASE_EOL row=5, col=70 -> 10 writes at addresses {70..79,5}; lastOpCount=10.
- STATUS cmdRow=0 -> 80 writes at row 31, data 127; initUpdateStatus pulses exactly once; initEnableN stays 1.
- termWrReq held high continuously, cmdValid raised -> exactly 8 termWrAck grants, then cmdReady; terminal data appears on the RAM only while initWrEn=0.
- Stub init engine that never asserts initWrEn -> return to IDLE 4 cycles after WAIT_START entry; startErr=1 stays set; no doneStrobe.
- resetn pulsed low mid-CLS (after 1000 writes) -> all outputs return to reset values asynchronously; next CLS completes with lastOpCount=2560.
